// File: rtl/registrador_rf_pkg.sv
// -----------------------------------------------------------------------------
// registrador_rf_pkg
// Shared constants for the datapath slice: register file (registrador),
// address adder (somador) and data memory (memoria). Keeping them in one
// place guarantees that the register word, memory word and address widths
// stay consistent across the three blocks.
// No ports (package only).
// -----------------------------------------------------------------------------
package registrador_rf_pkg;

    // Register file geometry
    localparam int RF_DATA_W   = 64;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

    // somador: adds two register indices; the carry-out widens the result,
    // which is then used as the memoria address.
    localparam int SOM_IN_W    = RF_ADDR_W;
    localparam int SOM_OUT_W   = RF_ADDR_W + 1;

    // memoria: word width matches the register file so dout can feed din.
    localparam int MEM_DATA_W  = RF_DATA_W;
    localparam int MEM_ADDR_W  = SOM_OUT_W;

endpackage : registrador_rf_pkg

// File: rtl/registrador_rf.sv
// -----------------------------------------------------------------------------
// registrador_rf
// 32-entry register file, one synchronous write port and two independent
// combinational read ports. Register 0 is an ordinary writable register.
//
// Ports
//   clk    in   1       rising-edge clock for all writes
//   rst_n  in   1       asynchronous active-low reset, clears every register
//   din    in   DATA_W  write data (driven by memoria dout in the system)
//   we     in   1       write enable, active high
//   Rw     in   ADDR_W  write register index
//   Ra     in   ADDR_W  read port A index
//   Rb     in   ADDR_W  read port B index
//   doutA  out  DATA_W  contents of register Ra
//   doutB  out  DATA_W  contents of register Rb
//
// Reads return the stored contents only; a write in the current cycle is not
// forwarded, so reading the index being written shows the old value until
// the capturing edge.
// -----------------------------------------------------------------------------
module registrador_rf
    import registrador_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] doutA,
    output logic [DATA_W-1:0] doutB
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Storage. Reset clears the whole array immediately; since reset has
    // priority over the clock, writes are ignored while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[Rw] <= din;
        end
    end

    // Two independent combinational read multiplexers.
    assign doutA = r_regs[Ra];
    assign doutB = r_regs[Rb];

endmodule : registrador_rf

// File: tb/tb_registrador_rf.sv
// -----------------------------------------------------------------------------
// tb_registrador_rf
// Self-checking bench for registrador_rf. A word array holds the expected
// register contents; it is updated by plain rules (write on an edge when
// enabled and out of reset, clear everything on reset).
// -----------------------------------------------------------------------------
module tb_registrador_rf;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          we;
    logic [AW-1:0] Rw;
    logic [AW-1:0] Ra;
    logic [AW-1:0] Rb;
    logic [DW-1:0] doutA;
    logic [DW-1:0] doutB;

    logic [DW-1:0] model [NR];

    int checks = 0;
    int errors = 0;

    registrador_rf #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .we    (we),
        .Rw    (Rw),
        .Ra    (Ra),
        .Rb    (Rb),
        .doutA (doutA),
        .doutB (doutB)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int idx,
                         input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s idx=%0d got=%h want=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    // Advance one rising edge, applying the write rule to the model, then
    // settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && we) model[Rw] = din;
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] val);
        we  = 1'b1;
        Rw  = idx;
        din = val;
        tick();
        we  = 1'b0;
    endtask

    task automatic read_pair(input string tag, input logic [AW-1:0] a,
                             input logic [AW-1:0] b);
        Ra = a;
        Rb = b;
        #1;
        check({tag, "_A"}, int'(a), doutA, model[a]);
        check({tag, "_B"}, int'(b), doutB, model[b]);
    endtask

    initial begin
        // ---------- reset ----------
        rst_n = 1'b0;
        we    = 1'b0;
        din   = '0;
        Rw    = '0;
        Ra    = '0;
        Rb    = '0;
        model_clear();
        #1;
        check("reset_hold_A", 0, doutA, 64'h0);
        // write attempt during reset must be ignored
        we  = 1'b1;
        Rw  = 5'd0;
        din = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        tick();
        we = 1'b0;
        check("write_in_reset", 0, doutA, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---------- reset sweep ----------
        for (int i = 0; i < NR; i++) read_pair("reset_sweep", 5'(i), 5'(31 - i));

        // ---------- single write ----------
        write_reg(5'd10, 64'h0123_4567_89AB_CDEF);
        Ra = 5'd10;
        Rb = 5'd11;
        #1;
        check("single_write_A", 10, doutA, 64'h0123_4567_89AB_CDEF);
        check("single_write_B", 11, doutB, 64'h0);

        // ---------- write disabled ----------
        we  = 1'b0;
        Rw  = 5'd10;
        din = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (5) tick();
        Ra = 5'd10;
        #1;
        check("write_disabled", 10, doutA, 64'h0123_4567_89AB_CDEF);

        // ---------- glitch between edges ----------
        #1;
        we  = 1'b1;
        Rw  = 5'd10;
        din = 64'h5555_5555_5555_5555;
        #2;
        we  = 1'b0;
        tick();
        Ra = 5'd10;
        #1;
        check("we_glitch", 10, doutA, 64'h0123_4567_89AB_CDEF);

        // ---------- read during write ----------
        write_reg(5'd5, 64'h1);
        we  = 1'b1;
        Rw  = 5'd5;
        Ra  = 5'd5;
        din = 64'h2;
        #1;
        check("rdw_before", 5, doutA, 64'h1);
        tick();
        we = 1'b0;
        check("rdw_after", 5, doutA, 64'h2);

        // ---------- full sweep ----------
        for (int i = 0; i < NR; i++)
            write_reg(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
        for (int i = 0; i < NR; i++) begin
            Ra = 5'(i);
            Rb = 5'(31 - i);
            #1;
            check("sweep_A", i, doutA, 64'(i) * 64'h0101_0101_0101_0101);
            check("sweep_B", 31 - i, doutB, 64'(31 - i) * 64'h0101_0101_0101_0101);
        end

        // ---------- async reset mid-cycle ----------
        Ra = 5'd31;
        Rb = 5'd1;
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_A", 31, doutA, 64'h0);
        check("async_rst_B", 1, doutB, 64'h0);
        #1;
        rst_n = 1'b1;
        write_reg(5'd7, 64'hA5A5_0000_FFFF_1234);
        read_pair("post_reset", 5'd7, 5'd31);

        // ---------- randomized traffic ----------
        for (int n = 0; n < 300; n++) begin
            we  = ($urandom_range(0, 99) < 60);
            Rw  = 5'($urandom_range(0, NR - 1));
            din = {$urandom, $urandom};
            Ra  = 5'($urandom_range(0, NR - 1));
            Rb  = (n % 7 == 0) ? Ra : 5'($urandom_range(0, NR - 1));
            if (n % 5 == 0) Ra = Rw;   // exercise read-during-write
            #1;
            check("rand_A", int'(Ra), doutA, model[Ra]);
            check("rand_B", int'(Rb), doutB, model[Rb]);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < NR; i++) read_pair("final_sweep", 5'(i), 5'(31 - i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_registrador_rf
